// File: rtl/surf_capture_pkg.sv
// surf_capture_pkg
//   Shared definitions for the SURF DOUT word capture block.
//   - capture_state_t : alignment / capture state machine encoding
//   - DEFAULT_TRAIN_PATTERN : idle byte the SURF sends between frames
//   - MAX_WORD_BYTES : largest supported assembled word, in bytes
package surf_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRAIN,
    SLIPWAIT,
    LOCKED,
    CAPTURE
  } capture_state_t;

  localparam logic [7:0] DEFAULT_TRAIN_PATTERN = 8'hA6;
  localparam int         MAX_WORD_BYTES        = 8;

endpackage

// File: rtl/surf_capture_errcnt.sv
// surf_capture_errcnt
//   Saturating up-counter with a synchronous clear that overrides increment.
//   Ports:
//     clk    in  1      : clock
//     rst_n  in  1      : asynchronous active-low reset
//     inc    in  1      : count one event this cycle
//     clr    in  1      : clear to zero (wins over inc)
//     count  out WIDTH  : current count, sticks at all-ones
module surf_capture_errcnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/surf_word_capture.sv
// surf_word_capture
//   Byte-alignment trainer and word assembler for the SURF DOUT path, placed
//   after the DOUT ISERDES on sysclk_i. Trains against TRAIN_PATTERN by
//   requesting bitslips, then assembles sync-aligned WORD_BYTES-byte words on
//   request while checking idle bytes for bit errors.
//
//   Build option: define SURF_CAPTURE_ERRCNT_EN to build the saturating error
//   counter (err_count_o / err_clear_i). Without it err_count_o is 0 and
//   err_clear_i is ignored.
//
//   Ports:
//     sysclk_i     in  1              : clock
//     rst_n_i      in  1              : asynchronous active-low reset
//     sync_i       in  1              : frame boundary strobe (aligned with dout_i)
//     enable_i     in  1              : block enable, low forces IDLE
//     capture_i    in  1              : word capture request (level, aligned with dout_i)
//     dout_i       in  8              : byte from ISERDES
//     bitslip_o    out 1              : one-cycle bitslip request
//     locked_o     out 1              : alignment achieved
//     data_o       out 8*WORD_BYTES   : assembled word, byte 0 in MSBs
//     valid_o      out 1              : one-cycle word strobe
//     biterr_o     out 1              : one-cycle idle mismatch strobe
//     err_clear_i  in  1              : clear error counter
//     err_count_o  out ERR_CNT_WIDTH  : saturating error count
module surf_word_capture
  import surf_capture_pkg::*;
#(
  parameter int         WORD_BYTES    = 4,
  parameter logic [7:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int         LOCK_COUNT    = 16,
  parameter int         LOSS_COUNT    = 4,
  parameter int         SLIP_WAIT     = 8,
  parameter int         ERR_CNT_WIDTH = 16
) (
  input  logic                     sysclk_i,
  input  logic                     rst_n_i,
  input  logic                     sync_i,
  input  logic                     enable_i,
  input  logic                     capture_i,
  input  logic [7:0]               dout_i,
  output logic                     bitslip_o,
  output logic                     locked_o,
  output logic [8*WORD_BYTES-1:0]  data_o,
  output logic                     valid_o,
  output logic                     biterr_o,
  input  logic                     err_clear_i,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

  localparam int         DW        = 8 * WORD_BYTES;
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);
  localparam logic [4:0] SLIP_LAST = 5'(SLIP_WAIT - 1);
  localparam logic [2:0] WORD_LAST = 3'(WORD_BYTES - 1);

  capture_state_t state_q, state_d;

  logic [7:0]    din_q;
  logic          sync_q;
  logic          cap_q;
  logic [7:0]    match_cnt_q, match_cnt_d;
  logic [3:0]    loss_cnt_q, loss_cnt_d;
  logic [4:0]    slip_cnt_q, slip_cnt_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic          armed_q, armed_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] word_asm;
  logic          take_byte;
  logic          word_load;
  logic          bitslip_d;
  logic          biterr_d;
  logic          valid_d;

  // Next-state logic. dout_i, sync_i and capture_i are registered together
  // so a byte and its sync/capture qualifiers are always judged as a unit.
  // take_byte marks a cycle whose registered byte belongs to a word, either
  // the sync-aligned byte 0 seen in LOCKED or any byte during CAPTURE.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    armed_d     = armed_q;
    shift_d     = shift_q;
    bitslip_d   = 1'b0;
    biterr_d    = 1'b0;
    valid_d     = 1'b0;
    word_load   = 1'b0;
    take_byte   = 1'b0;
    word_asm    = (shift_q << 8) | DW'(din_q);

    case (state_q)
      IDLE: begin
        match_cnt_d = '0;
        loss_cnt_d  = '0;
        slip_cnt_d  = '0;
        byte_cnt_d  = '0;
        armed_d     = 1'b0;
        if (enable_i) state_d = TRAIN;
      end

      TRAIN: begin
        if (din_q == TRAIN_PATTERN) begin
          if (match_cnt_q == LOCK_LAST) begin
            match_cnt_d = '0;
            loss_cnt_d  = '0;
            armed_d     = 1'b0;
            state_d     = LOCKED;
          end else begin
            match_cnt_d = match_cnt_q + 8'd1;
          end
        end else begin
          bitslip_d   = 1'b1;
          match_cnt_d = '0;
          slip_cnt_d  = '0;
          state_d     = SLIPWAIT;
        end
      end

      // The PHY needs time to settle after a slip, so bytes seen here are
      // never compared.
      SLIPWAIT: begin
        if (slip_cnt_q == SLIP_LAST) begin
          slip_cnt_d = '0;
          state_d    = TRAIN;
        end else begin
          slip_cnt_d = slip_cnt_q + 5'd1;
        end
      end

      // Arming is sticky until the word starts; a capture request in the
      // same cycle as sync starts immediately on that byte.
      LOCKED: begin
        if ((armed_q || cap_q) && sync_q) begin
          take_byte = 1'b1;
        end else begin
          if (cap_q) armed_d = 1'b1;
          if (din_q != TRAIN_PATTERN) begin
            biterr_d = 1'b1;
            if (loss_cnt_q == LOSS_LAST) begin
              loss_cnt_d  = '0;
              match_cnt_d = '0;
              armed_d     = 1'b0;
              state_d     = TRAIN;
            end else begin
              loss_cnt_d = loss_cnt_q + 4'd1;
            end
          end else begin
            loss_cnt_d = '0;
          end
        end
      end

      CAPTURE: begin
        take_byte = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A word byte is either shifted in or, if it is the last one, completes
    // the word. Holding capture_i at completion chains straight into the
    // next word without waiting for sync.
    if (take_byte) begin
      armed_d    = 1'b0;
      loss_cnt_d = '0;
      if (byte_cnt_q == WORD_LAST) begin
        valid_d    = 1'b1;
        word_load  = 1'b1;
        byte_cnt_d = '0;
        state_d    = cap_q ? CAPTURE : LOCKED;
      end else begin
        shift_d    = word_asm;
        byte_cnt_d = byte_cnt_q + 3'd1;
        state_d    = CAPTURE;
      end
    end

    // Disable overrides everything, dropping any partial word silently.
    if (!enable_i) begin
      state_d     = IDLE;
      match_cnt_d = '0;
      loss_cnt_d  = '0;
      slip_cnt_d  = '0;
      byte_cnt_d  = '0;
      armed_d     = 1'b0;
      bitslip_d   = 1'b0;
      biterr_d    = 1'b0;
      valid_d     = 1'b0;
      word_load   = 1'b0;
    end
  end

  // State, input pipeline and registered outputs. locked_o is taken from
  // the next state so it moves on the same edge as the state register.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      din_q       <= '0;
      sync_q      <= 1'b0;
      cap_q       <= 1'b0;
      match_cnt_q <= '0;
      loss_cnt_q  <= '0;
      slip_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      armed_q     <= 1'b0;
      shift_q     <= '0;
      bitslip_o   <= 1'b0;
      biterr_o    <= 1'b0;
      valid_o     <= 1'b0;
      locked_o    <= 1'b0;
      data_o      <= '0;
    end else begin
      state_q     <= state_d;
      din_q       <= dout_i;
      sync_q      <= sync_i;
      cap_q       <= capture_i;
      match_cnt_q <= match_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      slip_cnt_q  <= slip_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      armed_q     <= armed_d;
      shift_q     <= shift_d;
      bitslip_o   <= bitslip_d;
      biterr_o    <= biterr_d;
      valid_o     <= valid_d;
      locked_o    <= (state_d == LOCKED) || (state_d == CAPTURE);
      if (word_load) data_o <= word_asm;
    end
  end

`ifdef SURF_CAPTURE_ERRCNT_EN
  // Driven from the same combinational strobe as biterr_o so the count
  // moves on the same edge the strobe rises.
  surf_capture_errcnt #(
    .WIDTH (ERR_CNT_WIDTH)
  ) u_errcnt (
    .clk   (sysclk_i),
    .rst_n (rst_n_i),
    .inc   (biterr_d),
    .clr   (err_clear_i),
    .count (err_count_o)
  );
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear_i;
  assign err_count_o      = '0;
`endif

endmodule
